// File: rtl/fir_decim.sv
// fir_decim: decimating FIR filter with a run-time loadable coefficient bank.
//
// Input samples are shifted into a TAPS-deep history (index 0 = newest).
// Every DECIM accepted samples the block stops accepting input and runs one
// multiply-accumulate per cycle over all taps. Each product is scaled down by
// 2^BITS with truncation toward zero. The sum is then presented on out_data
// with a valid/ready handshake.
//
// Ports
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high reset
//   in_data    : signed input sample (DATA_WIDTH)
//   in_valid   : in_data valid
//   in_ready   : block accepts in_data this cycle (only while accepting)
//   out_data   : signed filtered, decimated sample (DATA_WIDTH)
//   out_valid  : out_data valid, held until out_ready
//   out_ready  : downstream accepts out_data
//   coef_wr    : coefficient write strobe (honoured only while accepting)
//   coef_addr  : tap index of the coefficient write
//   coef_data  : signed coefficient, 1.0 = 2^BITS
module fir_decim #(
  parameter int TAPS       = 32,
  parameter int DECIM      = 8,
  parameter int BITS       = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  coef_wr,
  input  logic [4:0]            coef_addr,
  input  logic [DATA_WIDTH-1:0] coef_data
);

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_MAC    = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  // The tap counter has to reach TAPS itself, which marks the load cycle.
  localparam int CW = $clog2(TAPS + 1);
  localparam int PRODW = 2 * DATA_WIDTH;

  localparam logic [PW-1:0]    PHASE_LAST = PW'(DECIM - 32'sd1);
  localparam logic [CW-1:0]    TAP_DONE   = CW'(TAPS);
  // Bias added to negative products so the arithmetic shift rounds toward zero.
  localparam logic [PRODW-1:0] RND_MASK   = PRODW'((64'd1 << BITS) - 64'd1);

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic                  in_ready_r;
  logic [PW-1:0]         phase_r;
  logic [CW-1:0]         tap_r;
  logic [DATA_WIDTH-1:0] sample_r [TAPS];
  logic [DATA_WIDTH-1:0] coef_r [TAPS];
  logic [DATA_WIDTH-1:0] acc_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r;

  logic                  accept_s;
  logic                  last_phase_s;
  logic                  mac_last_s;
  logic                  coef_we_s;
  logic [TW-1:0]         tap_idx_s;
  logic signed [PRODW-1:0] samp_ext_s;
  logic signed [PRODW-1:0] coef_ext_s;
  logic signed [PRODW-1:0] prod_s;
  logic signed [PRODW-1:0] prod_adj_s;
  logic [DATA_WIDTH-1:0]   term_s;

  assign accept_s     = in_valid && (state_r == ST_ACCEPT);
  assign last_phase_s = (phase_r == PHASE_LAST);
  assign mac_last_s   = (tap_r == TAP_DONE);
  assign coef_we_s    = coef_wr && (state_r == ST_ACCEPT) && (int'(coef_addr) < TAPS);

  assign in_ready  = in_ready_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;

  // Tap selection and scaled product for the current MAC step.
  always_comb begin
    tap_idx_s  = '0;
    samp_ext_s = '0;
    coef_ext_s = '0;
    prod_s     = '0;
    prod_adj_s = '0;
    term_s     = '0;
    // The load cycle (tap_r == TAPS) has no tap; park the index at 0.
    if (mac_last_s) begin
      tap_idx_s = '0;
    end else begin
      tap_idx_s = tap_r[TW-1:0];
    end
    samp_ext_s = PRODW'($signed(sample_r[tap_idx_s]));
    coef_ext_s = PRODW'($signed(coef_r[tap_idx_s]));
    prod_s     = samp_ext_s * coef_ext_s;
    if (prod_s[PRODW-1]) begin
      prod_adj_s = prod_s + RND_MASK;
    end else begin
      prod_adj_s = prod_s;
    end
    term_s = DATA_WIDTH'(prod_adj_s >>> BITS);
  end

  // Next-state decode for the accept / MAC / output sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACCEPT: begin
        if (accept_s && last_phase_s) begin
          state_nxt_s = ST_MAC;
        end else begin
          state_nxt_s = ST_ACCEPT;
        end
      end
      ST_MAC: begin
        if (mac_last_s) begin
          state_nxt_s = ST_OUTPUT;
        end else begin
          state_nxt_s = ST_MAC;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_nxt_s = ST_ACCEPT;
        end else begin
          state_nxt_s = ST_OUTPUT;
        end
      end
      default: state_nxt_s = ST_ACCEPT;
    endcase
  end

  // State register; in_ready is registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_ACCEPT;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == ST_ACCEPT);
    end
  end

  // Coefficient bank, writable only while accepting samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_r[i] <= '0;
      end
    end else if (coef_we_s) begin
      coef_r[coef_addr[TW-1:0]] <= coef_data;
    end
  end

  // Sample history shift and decimation phase counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_r <= '0;
      for (int i = 0; i < TAPS; i++) begin
        sample_r[i] <= '0;
      end
    end else if (accept_s) begin
      sample_r[0] <= in_data;
      for (int i = 1; i < TAPS; i++) begin
        sample_r[i] <= sample_r[i-1];
      end
      if (last_phase_s) begin
        phase_r <= '0;
      end else begin
        phase_r <= phase_r + PW'(1'b1);
      end
    end
  end

  // Accumulator and tap counter: cleared on MAC entry, one tap per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_r <= '0;
      tap_r <= '0;
    end else if (accept_s && last_phase_s) begin
      acc_r <= '0;
      tap_r <= '0;
    end else if ((state_r == ST_MAC) && !mac_last_s) begin
      acc_r <= acc_r + term_s;
      tap_r <= tap_r + CW'(1'b1);
    end
  end

  // Output register: loaded after the last tap, held until handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if ((state_r == ST_MAC) && mac_last_s) begin
      out_data_r  <= acc_r;
      out_valid_r <= 1'b1;
    end else if ((state_r == ST_OUTPUT) && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decim.sv
// Self-checking bench for fir_decim with a behavioural reference model.
module tb_fir_decim;

  localparam int TAPS  = 32;
  localparam int DECIM = 8;
  localparam int BITS  = 10;
  localparam int DW    = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          coef_wr;
  logic [4:0]    coef_addr;
  logic [DW-1:0] coef_data;

  int total = 0;
  int bad   = 0;

  // Reference model state: newest-first history, coefficients, phase.
  int hist[$];
  int coef_m[TAPS];
  int phase_m;
  int exp_q[$];
  bit fired;

  fir_decim #(.TAPS(TAPS), .DECIM(DECIM), .BITS(BITS), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < TAPS; i++) begin
      hist.push_back(0);
      coef_m[i] = 0;
    end
    phase_m = 0;
    exp_q.delete();
  endfunction

  // Filter output from plain arithmetic: 64-bit product, division truncates toward zero.
  function automatic int model_out();
    int acc = 0;
    longint p;
    longint t;
    for (int i = 0; i < TAPS; i++) begin
      p = longint'(hist[i]) * longint'(coef_m[i]);
      t = p / (longint'(1) << BITS);
      acc = acc + int'(t);
    end
    return acc;
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    coef_wr   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_wr   = 1'b1;
    coef_addr = addr[4:0];
    coef_data = data;
    @(posedge clock);
    #1 coef_wr = 1'b0;
    if (addr < TAPS) coef_m[addr] = data;
  endtask

  // Offer one sample (optionally with a coefficient write in the same cycle).
  task automatic push(input int v, input bit wr, input int waddr, input int wdata, output bit f);
    chk("push_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = v;
    if (wr) begin
      coef_wr   = 1'b1;
      coef_addr = waddr[4:0];
      coef_data = wdata;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    coef_wr  = 1'b0;
    if (wr && waddr < TAPS) coef_m[waddr] = wdata;
    hist.push_front(v);
    void'(hist.pop_back());
    phase_m++;
    f = 1'b0;
    if (phase_m == DECIM) begin
      phase_m = 0;
      exp_q.push_back(model_out());
      f = 1'b1;
    end
  endtask

  // Wait for the result of the sample just accepted; hold off out_ready for 'hold' cycles.
  task automatic wait_out(input string tag, input int hold);
    int n = 0;
    int busy = 0;
    int expv;
    expv = exp_q.pop_front();
    if (in_ready !== 1'b0) busy++;
    // Traffic during the busy period that the block must ignore.
    in_valid  = 1'b1;
    in_data   = $urandom;
    coef_wr   = 1'b1;
    coef_addr = 5'd0;
    coef_data = $urandom;
    while (n < 100) begin
      @(posedge clock);
      #1;
      n++;
      coef_wr = 1'b0;
      if (in_ready !== 1'b0) busy++;
      if (out_valid === 1'b1) break;
    end
    chk({tag, "_latency"}, n, TAPS + 1);
    chk({tag, "_in_ready_low"}, busy, 0);
    chk({tag, "_data"}, out_data, expv);
    for (int k = 0; k < hold; k++) begin
      @(posedge clock);
      #1;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_data"}, out_data, expv);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    chk({tag, "_rel_valid"}, out_valid, 0);
    chk({tag, "_rel_in_ready"}, in_ready, 1);
    chk({tag, "_rel_data"}, out_data, expv);
  endtask

  initial begin
    int viol;
    int nout;

    // Reset state
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);

    // Passthrough: coef[0] = 1.0, samples 1..16
    write_coef(0, 1024);
    for (int v = 1; v <= 16; v++) begin
      push(v, 1'b0, 0, 0, fired);
      if (fired) wait_out("pass", 0);
    end

    // Truncation toward zero: -0.5 * 3
    do_reset();
    write_coef(0, -512);
    for (int i = 0; i < 8; i++) begin
      push((i == 7) ? 3 : 0, 1'b0, 0, 0, fired);
      if (fired) wait_out("round", 0);
    end

    // All taps 1.0, constant 5; backpressure on the second output
    do_reset();
    for (int a = 0; a < TAPS; a++) write_coef(a, 1024);
    nout = 0;
    for (int i = 0; i < 32; i++) begin
      push(5, 1'b0, 0, 0, fired);
      if (fired) begin
        wait_out("sum", (nout == 1) ? 5 : 0);
        nout++;
      end
    end

    // Random coefficients and samples, coefficient writes alongside accepts
    do_reset();
    for (int a = 0; a < TAPS; a++) write_coef(a, $urandom);
    for (int i = 0; i < 48; i++) begin
      push($urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, TAPS - 1), $urandom, fired);
      if (fired) wait_out("rand", $urandom_range(0, 3));
    end

    // Reset ten cycles into MAC aborts the result
    do_reset();
    write_coef(0, 1024);
    write_coef(3, 77);
    for (int i = 0; i < 8; i++) push($urandom, 1'b0, 0, 0, fired);
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_data", out_data, 0);
    viol = 0;
    for (int c = 0; c < 45; c++) begin
      if (out_valid !== 1'b0) viol++;
      @(posedge clock);
      #1;
    end
    chk("midrst_no_valid", viol, 0);
    write_coef(0, 1024);
    for (int i = 0; i < 8; i++) begin
      push(7, 1'b0, 0, 0, fired);
      if (fired) wait_out("post_rst", 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_decim.md
FIR_DECIM -- requirements
Module: fir_decim

Interface
REQ-001 SHALL have parameter TAPS, default 32, number of FIR taps (1..32).
REQ-002 SHALL have parameter DECIM, default 8, input samples per output sample (audio decimation).
REQ-003 SHALL have parameter BITS, default 10, coefficient fraction bits (1.0 = 1024).
REQ-004 SHALL have parameter DATA_WIDTH, default 32, signed sample/coefficient width.
REQ-005 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  signed quantized input sample.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  signed filtered, decimated sample.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port coef_wr  input  1  coefficient write strobe.
REQ-014 SHALL have port coef_addr  input  5  tap index 0..TAPS-1.
REQ-015 SHALL have port coef_data  input  DATA_WIDTH  signed quantized coefficient.

Function
REQ-016 SHALL implement states ACCEPT, MAC, OUTPUT; in_ready = 1 only in ACCEPT.
REQ-017 SHALL, on in_valid & in_ready, shift sample history (index 0 = newest, index TAPS-1 discarded) and increment phase counter 0..DECIM-1.
REQ-018 SHALL, when the accepted sample makes the counter reach DECIM, wrap counter to 0 and enter MAC at that same edge; otherwise remain in ACCEPT.
REQ-019 SHALL in MAC process one tap per cycle, i = 0..TAPS-1: acc += trunc0((sample[i] * coef[i]) / 2^BITS), product full 2*DATA_WIDTH signed, division truncating toward zero, acc DATA_WIDTH-bit two's-complement wrap.
REQ-020 SHALL clear acc at MAC entry; after tap TAPS-1 SHALL load out_data = acc, assert out_valid, enter OUTPUT.
REQ-021 SHALL assert out_valid exactly TAPS+1 rising edges after the edge accepting the DECIM-th sample.
REQ-022 SHALL in OUTPUT hold out_data and out_valid stable until out_valid & out_ready; on that edge deassert out_valid and return to ACCEPT (in_ready = 1 next cycle).
REQ-023 SHALL accept no input in MAC or OUTPUT; in_valid during those states is ignored (upstream holds data).
REQ-024 SHALL write coef[coef_addr] = coef_data on coef_wr only in ACCEPT; coef_wr in MAC/OUTPUT ignored; coef_addr >= TAPS ignored.
REQ-025 SHALL apply coef_wr and sample accept in the same ACCEPT cycle independently; new coefficient used from the next MAC.
REQ-026 SHALL keep out_data unchanged when out_valid = 0 except at the load edge.

Reset
REQ-027 SHALL on reset clear sample history, coefficients, acc, phase counter, out_data to 0, out_valid to 0, state to ACCEPT (in_ready = 1 the cycle after reset).
REQ-028 SHALL, on reset asserted in any state including mid-MAC or OUTPUT, abort in-flight computation with no out_valid pulse.

Verification
REQ-029 SHALL pass passthrough: coef[0]=1024, others 0; feed 1..16 with out_ready=1 -> outputs 8 then 16.
REQ-030 SHALL pass latency: out_valid rises exactly 33 edges after 8th accepted sample (TAPS=32); in_ready low during those 33 cycles.
REQ-031 SHALL pass rounding: coef[0]=-512; feed seven 0s then 3 -> out_data = -1 (-1536/1024 truncated toward zero).
REQ-032 SHALL pass sum: all 32 coef=1024; feed 32 samples of value 5 -> 4th output = 160, earlier outputs 40, 80, 120.
REQ-033 SHALL pass backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, out_valid=1, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
REQ-034 SHALL pass reset mid-MAC: reset 10 cycles into MAC -> no out_valid; with coef[0] rewritten to 1024, next 8 samples of 7 -> out_data = 7.
